// File: rtl/bsg_fpu_i2f_sched_pkg.sv
// bsg_fpu_i2f_sched_pkg
// Shared types and constants for the int->float converter scheduler.
// The optional statistics counters (macro BSG_FPU_I2F_SCHED_STATS_EN) use
// the counter width defined here.
package bsg_fpu_i2f_sched_pkg;

  // Scheduler state: nothing in flight, result in converter stage, or
  // issue stopped while a pending result is drained.
  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eBusy  = 2'd1,
    eDrain = 2'd2
  } state_e;

  // Width of every statistics counter (wraps on overflow).
  localparam int StatsCntWidth = 32;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// bsg_arb_round_robin
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer one past the winner whenever the grant is used.
module bsg_arb_round_robin #(
  parameter int num_req_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [num_req_p-1:0]                 reqs_i,
  input  logic                                 yumi_i,
  output logic [num_req_p-1:0]                 grants_o,
  output logic [$clog2(num_req_p)-1:0]         grant_id_o
);

  localparam int tag_width_lp = $clog2(num_req_p);

  logic [tag_width_lp-1:0] r_ptr;
  logic                    w_found;
  int                      w_idx;

  // Search requesters starting at the pointer, wrapping around once.
  always_comb begin
    w_found    = 1'b0;
    w_idx      = 0;
    grant_id_o = '0;
    grants_o   = '0;
    for (int i = 0; i < num_req_p; i++) begin
      w_idx = (int'(r_ptr) + i) % num_req_p;
      if (!w_found && reqs_i[w_idx]) begin
        w_found    = 1'b1;
        grant_id_o = tag_width_lp'(w_idx);
      end
    end
    if (w_found) begin
      grants_o[grant_id_o] = 1'b1;
    end
  end

  // Advance the pointer past the winner only when the grant is consumed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (yumi_i) begin
      r_ptr <= (grant_id_o == tag_width_lp'(num_req_p - 1)) ? '0 : grant_id_o + 1'b1;
    end
  end

endmodule

// File: rtl/bsg_fpu_i2f_sched.sv
// bsg_fpu_i2f_sched
// Shares one single-stage int->float converter among num_req_p requesters.
// Requests are issued round-robin; an owner tag travels with the converter
// stage so each result is steered back to the requester that issued it.
// Optional per-requester issue and stall counters are built when the macro
// BSG_FPU_I2F_SCHED_STATS_EN is defined.
module bsg_fpu_i2f_sched
  import bsg_fpu_i2f_sched_pkg::*;
#(
  parameter int e_p       = 8,
  parameter int m_p       = 23,
  parameter int num_req_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              en_i,
  input  logic [num_req_p-1:0]              v_i,
  input  logic [num_req_p-1:0]              signed_i,
  input  logic [num_req_p*(e_p+m_p+1)-1:0]  a_i,
  output logic [num_req_p-1:0]              ready_o,
  output logic [num_req_p-1:0]              v_o,
  output logic [e_p+m_p:0]                  z_o,
  input  logic [num_req_p-1:0]              yumi_i,
  output logic                              busy_o,
  output logic                              cvt_en_o,
  output logic                              cvt_v_o,
  output logic                              cvt_signed_o,
  output logic [e_p+m_p:0]                  cvt_a_o,
  input  logic                              cvt_ready_i,
  input  logic                              cvt_v_i,
  input  logic [e_p+m_p:0]                  cvt_z_i,
  output logic                              cvt_yumi_o
`ifdef BSG_FPU_I2F_SCHED_STATS_EN
  ,
  output logic [num_req_p*StatsCntWidth-1:0] stats_issue_o,
  output logic [StatsCntWidth-1:0]           stats_stall_o
`endif
);

  localparam int width_lp     = e_p + m_p + 1;
  localparam int tag_width_lp = $clog2(num_req_p);

  state_e                  r_state;
  logic [tag_width_lp-1:0] r_tag;
  logic [num_req_p-1:0]    w_grantOh;
  logic [tag_width_lp-1:0] w_grantId;
  logic                    w_anyReq;
  logic                    w_issue;
  logic                    w_anyYumi;

  bsg_arb_round_robin #(
    .num_req_p (num_req_p)
  ) arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (v_i),
    .yumi_i     (w_issue),
    .grants_o   (w_grantOh),
    .grant_id_o (w_grantId)
  );

  assign w_anyReq     = |v_i;
  assign cvt_v_o      = ~reset_i & en_i & w_anyReq;
  assign w_issue      = cvt_v_o & cvt_ready_i;
  assign ready_o      = (reset_i | ~en_i | ~cvt_ready_i) ? '0 : w_grantOh;
  assign cvt_signed_o = signed_i[w_grantId];
  assign cvt_a_o      = a_i[w_grantId*width_lp +: width_lp];
  assign cvt_en_o     = en_i | (r_state == eDrain);
  assign z_o          = cvt_z_i;
  assign w_anyYumi    = |(yumi_i & v_o);
  assign cvt_yumi_o   = w_anyYumi;
  assign busy_o       = (r_state != eIdle);

  // Route the converter's valid to the owner recorded when the op was issued.
  always_comb begin
    v_o = '0;
    if (!reset_i && cvt_v_i) begin
      v_o[r_tag] = 1'b1;
    end
  end

  // Owner tag and scheduler state; the tag only moves on an issue, which the
  // converter refuses while an unconsumed result is still in its stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIdle;
      r_tag   <= '0;
    end else begin
      if (w_issue) begin
        r_tag <= w_grantId;
      end
      unique case (r_state)
        eIdle: begin
          if (w_issue) r_state <= eBusy;
        end
        eBusy: begin
          if (!en_i) r_state <= eDrain;
          else if (w_anyYumi && !w_issue) r_state <= eIdle;
        end
        eDrain: begin
          if (w_issue) r_state <= eBusy;
          else if (w_anyYumi) r_state <= eIdle;
        end
        default: r_state <= eIdle;
      endcase
    end
  end

`ifdef BSG_FPU_I2F_SCHED_STATS_EN
  logic [num_req_p-1:0][StatsCntWidth-1:0] r_issueCnt;
  logic [StatsCntWidth-1:0]                r_stallCnt;

  // Count accepted ops per requester and cycles where a request waited.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_issueCnt <= '0;
      r_stallCnt <= '0;
    end else begin
      for (int r = 0; r < num_req_p; r++) begin
        if (w_issue && (w_grantId == tag_width_lp'(r))) begin
          r_issueCnt[r] <= r_issueCnt[r] + 1'b1;
        end
      end
      if (w_anyReq && !w_issue) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
    end
  end

  assign stats_issue_o = r_issueCnt;
  assign stats_stall_o = r_stallCnt;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
